// File: rtl/bsg_age_tracker_pkg.sv
// bsg_age_tracker_pkg: shared types and helpers for the age tracker.
//   age_state_e : per-lane state (e_age_idle, e_age_pend)
//   ts_max()    : largest age value a ts_width-bit counter can hold
package bsg_age_tracker_pkg;

    typedef enum logic {
        e_age_idle = 1'b0,
        e_age_pend = 1'b1
    } age_state_e;

    function automatic int unsigned ts_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/bsg_age_tracker_lane.sv
// bsg_age_tracker_lane: IDLE/PEND state and age counter for one client lane.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i              : client request level
//   grant_i          : lane granted this cycle (grant bit already qualified by ready)
//   sat_any_i        : some ungranted pending lane sits at max age (rescale build only)
//   sat_o            : this lane is ungranted, pending and at max age (rescale build only)
//   req_o            : lane is pending (registered)
//   yumi_o           : request consumed this cycle
//   drop_err_o       : client dropped v_i while pending and ungranted
//   age_o            : lane age, 0 while idle
// Build option: BSG_AGE_TRACKER_RESCALE_EN enables halving ages when any lane saturates.
module bsg_age_tracker_lane
    import bsg_age_tracker_pkg::*;
#(
    parameter int ts_width_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  v_i,
    input  logic                  grant_i,
`ifdef BSG_AGE_TRACKER_RESCALE_EN
    input  logic                  sat_any_i,
    output logic                  sat_o,
`endif
    output logic                  req_o,
    output logic                  yumi_o,
    output logic                  drop_err_o,
    output logic [ts_width_p-1:0] age_o
);

    localparam logic [ts_width_p-1:0] max_lp = ts_width_p'(ts_max(ts_width_p));
    localparam logic [ts_width_p-1:0] one_lp = ts_width_p'(1);

    age_state_e            state_q, state_d;
    logic [ts_width_p-1:0] age_q, age_d, age_inc;
    logic                  pend, at_max;

    always_comb begin
        pend       = (state_q == e_age_pend);
        at_max     = (age_q == max_lp);
        req_o      = pend;
        yumi_o     = pend & grant_i;
        drop_err_o = pend & ~v_i & ~grant_i;
        age_o      = pend ? age_q : '0;
`ifdef BSG_AGE_TRACKER_RESCALE_EN
        sat_o      = pend & ~grant_i & at_max;
        // Halving every waiting lane together keeps older lanes ahead of newer ones.
        age_inc    = sat_any_i ? (age_q >> 1) + one_lp : age_q + one_lp;
`else
        age_inc    = at_max ? age_q : age_q + one_lp;
`endif
        state_d    = pend ? (grant_i ? e_age_idle : e_age_pend)
                          : (v_i ? e_age_pend : e_age_idle);
        age_d      = (pend & ~grant_i) ? age_inc : '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_age_idle;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: rtl/bsg_age_tracker.sv
// bsg_age_tracker: client-side front end for bsg_age_arb; turns client valid
// levels into registered requests plus per-lane ages, and closes handshakes on grant.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i / yumi_o     : client request levels / per-client consume strobes
//   ready_i          : downstream can take a grant; passed through as arb_ready_o
//   reqs_o, ts_o     : registered request vector and packed lane ages to the arbiter
//   grants_i         : grant vector from the arbiter
//   err_o            : sticky protocol error (multi-grant, idle grant, dropped valid)
// Build option: BSG_AGE_TRACKER_RESCALE_EN enables age rescaling on saturation.
module bsg_age_tracker
    import bsg_age_tracker_pkg::*;
#(
    parameter int inputs_p   = 4,
    parameter int ts_width_p = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [inputs_p-1:0]            v_i,
    output logic [inputs_p-1:0]            yumi_o,
    input  logic                           ready_i,
    output logic                           arb_ready_o,
    output logic [inputs_p-1:0]            reqs_o,
    output logic [inputs_p*ts_width_p-1:0] ts_o,
    input  logic [inputs_p-1:0]            grants_i,
    output logic                           err_o
);

    logic [inputs_p-1:0]   grant_v, drop_err;
    logic [ts_width_p-1:0] age [inputs_p];
    logic                  multi_grant, idle_grant;
    logic                  err_q, err_d;
`ifdef BSG_AGE_TRACKER_RESCALE_EN
    logic [inputs_p-1:0]   sat;
    logic                  sat_any;
    assign sat_any = |sat;
`endif

    for (genvar k = 0; k < inputs_p; k++) begin : g_lane
        bsg_age_tracker_lane #(
            .ts_width_p(ts_width_p)
        ) u_lane (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .v_i        (v_i[k]),
            .grant_i    (grant_v[k]),
`ifdef BSG_AGE_TRACKER_RESCALE_EN
            .sat_any_i  (sat_any),
            .sat_o      (sat[k]),
`endif
            .req_o      (reqs_o[k]),
            .yumi_o     (yumi_o[k]),
            .drop_err_o (drop_err[k]),
            .age_o      (age[k])
        );
        assign ts_o[k*ts_width_p +: ts_width_p] = age[k];
    end

    always_comb begin
        grant_v     = grants_i & {inputs_p{ready_i}};
        // x & (x-1) is nonzero exactly when more than one bit is set.
        multi_grant = |(grants_i & (grants_i - inputs_p'(1)));
        idle_grant  = |(grants_i & ~reqs_o);
        err_d       = err_q | (ready_i & (multi_grant | idle_grant)) | (|drop_err);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) err_q <= 1'b0;
        else            err_q <= err_d;
    end

    assign err_o       = err_q;
    assign arb_ready_o = ready_i;

endmodule

// File: tb/tb_bsg_age_tracker.sv
// tb_bsg_age_tracker: directed self-checking bench for bsg_age_tracker (4 lanes, 4-bit ages).
module tb_bsg_age_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  v, yumi, grants, reqs;
    logic        ready, arb_ready, err;
    logic [15:0] ts;
    int          total = 0;
    int          bad   = 0;

    bsg_age_tracker #(.inputs_p(4), .ts_width_p(4)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .v_i         (v),
        .yumi_o      (yumi),
        .ready_i     (ready),
        .arb_ready_o (arb_ready),
        .reqs_o      (reqs),
        .ts_o        (ts),
        .grants_i    (grants),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; v = '0; ready = 1'b1; grants = '0;
        #1;
        chk("rst_reqs", 32'(reqs), 0);
        chk("rst_ts", 32'(ts), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_yumi", 32'(yumi), 0);
        chk("rst_arb_ready", 32'(arb_ready), 1);
        tick(); tick();
        reset_n = 1'b1;
        // single lane aging then grant
        v = 4'b0001; #1;
        chk("t1_yumi_idle", 32'(yumi), 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t1_reqs_c%0d", c), 32'(reqs), 32'h1);
            chk($sformatf("t1_ts_c%0d", c), 32'(ts), 32'(c - 1));
        end
        tick();
        grants = 4'b0001; #1;
        chk("t1_yumi_grant", 32'(yumi), 32'h1);
        chk("t1_ts_c6", 32'(ts), 5);
        tick();
        v = '0; grants = '0; #1;
        chk("t1_reqs_after", 32'(reqs), 0);
        chk("t1_err", 32'(err), 0);
        // re-request with v held: grants no closer than every 2 cycles
        v = 4'b0001;
        tick();
        chk("rr_reqs_a", 32'(reqs), 32'h1);
        grants = 4'b0001; #1;
        chk("rr_yumi_a", 32'(yumi), 32'h1);
        tick();
        grants = '0; #1;
        chk("rr_reqs_gap", 32'(reqs), 0);
        tick();
        chk("rr_reqs_b", 32'(reqs), 32'h1);
        chk("rr_ts_b", 32'(ts), 0);
        grants = 4'b0001; #1;
        chk("rr_yumi_b", 32'(yumi), 32'h1);
        tick();
        v = '0; grants = '0; #1;
        chk("rr_reqs_end", 32'(reqs), 0);
        chk("rr_err", 32'(err), 0);
        // staggered ages
        v = 4'b0001;
        tick(); tick(); tick();
        v = 4'b0101;
        tick(); tick(); tick();
        chk("t2_ts", 32'(ts), 32'h0205);
        chk("t2_reqs", 32'(reqs), 32'h5);
        // grants ignored while not ready
        ready = 1'b0; grants = 4'b0001; #1;
        chk("t3_yumi_c6", 32'(yumi), 0);
        chk("t3_arb_ready", 32'(arb_ready), 0);
        tick();
        chk("t3_ts_c7", 32'(ts), 32'h0306);
        chk("t3_yumi_c7", 32'(yumi), 0);
        tick();
        chk("t3_ts_c8", 32'(ts), 32'h0407);
        chk("t3_err", 32'(err), 0);
        tick();
        ready = 1'b1; #1;
        chk("t3_yumi_lane0", 32'(yumi), 32'h1);
        chk("t3_ts_c9", 32'(ts), 32'h0508);
        tick();
        v = 4'b0100; grants = 4'b0100; #1;
        chk("t3_yumi_lane2", 32'(yumi), 32'h4);
        chk("t3_reqs_c10", 32'(reqs), 32'h4);
        tick();
        v = '0; grants = '0; #1;
        chk("t3_reqs_end", 32'(reqs), 0);
        chk("t3_err_end", 32'(err), 0);
        // saturation (or rescaling) with two lanes
        v = 4'b0001;
        repeat (8) tick();
        v = 4'b0011;
        repeat (8) tick();
        chk("t4_ts_c16", 32'(ts), 32'h007F);
        tick();
`ifdef BSG_AGE_TRACKER_RESCALE_EN
        chk("t4_ts_c17", 32'(ts), 32'h0048);
`else
        chk("t4_ts_c17", 32'(ts), 32'h008F);
`endif
        tick(); tick(); tick();
`ifdef BSG_AGE_TRACKER_RESCALE_EN
        chk("t4_ts_c20", 32'(ts), 32'h007B);
`else
        chk("t4_ts_c20", 32'(ts), 32'h00BF);
`endif
        // multi-grant: both complete, error next cycle
        grants = 4'b0011; #1;
        chk("t5_yumi_multi", 32'(yumi), 32'h3);
        chk("t5_err_pre", 32'(err), 0);
        tick();
        v = '0; grants = '0; #1;
        chk("t5_err_multi", 32'(err), 1);
        chk("t5_reqs_multi", 32'(reqs), 0);
        #3 reset_n = 1'b0;
        #1 chk("t5_err_rst", 32'(err), 0);
        #1 reset_n = 1'b1;
        tick();
        // grant to an idle lane
        grants = 4'b0100; #1;
        chk("t5_yumi_idle", 32'(yumi), 0);
        tick();
        grants = '0; #1;
        chk("t5_err_idle", 32'(err), 1);
        tick(); tick();
        chk("t5_err_sticky", 32'(err), 1);
        // async reset mid-cycle with three lanes pending
        v = 4'b0111;
        tick(); tick();
        chk("t6_reqs_pre", 32'(reqs), 32'h7);
        chk("t6_ts_pre", 32'(ts), 32'h0111);
        chk("t6_err_pre", 32'(err), 1);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_reqs_rst", 32'(reqs), 0);
        chk("t6_ts_rst", 32'(ts), 0);
        chk("t6_err_rst", 32'(err), 0);
        chk("t6_yumi_rst", 32'(yumi), 0);
        #1 reset_n = 1'b1;
        #1 chk("t6_reqs_released", 32'(reqs), 0);
        tick();
        chk("t6_reqs_back", 32'(reqs), 32'h7);
        chk("t6_ts_back", 32'(ts), 0);
        chk("t6_err_back", 32'(err), 0);
        // dropping v while pending: error, lane stays pending
        v = 4'b0110;
        tick();
        chk("t7_err_drop", 32'(err), 1);
        chk("t7_reqs_drop", 32'(reqs), 32'h7);
        chk("t7_ts_drop", 32'(ts), 32'h0111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
